vm_result_proc: RTL and testbench

- Downstream stage of the multislope ADC sequencer.
- Consumes each 48-bit conversion result the sequencer latches at the end of rundown, before UART framing.
- Decodes the runup/rundown fields and scales them into one signed 32-bit reading.
- Averages 2^AVG_LOG2 readings and presents the mean on a valid/ready output toward the TX framer or host logic.

---
 rtl/vm_result_proc.sv | 205 ++++++++++++++++++++
 tb/tb_vm_result_proc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_result_proc.sv
// Multislope ADC result processor: decodes runup/rundown fields, scales them to a signed
// reading, averages 2^AVG_LOG2 readings. Define VM_RANGE_CHECK_EN to reject out-of-range samples.
module vm_result_proc #(
  parameter int unsigned RUNUP_WEIGHT = 3200,
  parameter int unsigned AVG_LOG2     = 2
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        res_valid,
  input  logic [47:0] res_data,
  input  logic        clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        ovf,
  output logic        err_range
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_MUL,
    S_ACC,
    S_OUT
  } state_t;

  localparam logic [4:0]  AVG_N    = 5'(1 << AVG_LOG2);
  localparam logic [29:0] WEIGHT   = 30'(RUNUP_WEIGHT);
  localparam logic [4:0]  MUL_LAST = 5'd16;

  state_t       state_q, state_d;
  logic [46:0]  data_q, data_d;
  logic [16:0]  mult_q, mult_d;
  logic         neg_q, neg_d;
  logic [29:0]  mcand_q, mcand_d;
  logic [29:0]  prod_q, prod_d;
  logic [4:0]   bit_q, bit_d;
  logic [35:0]  acc_q, acc_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [31:0]  out_data_q, out_data_d;
  logic         ovf_q, ovf_d;

  logic [14:0]  runup_cnt, runup_set;
  logic         rundown_sign;
  logic [15:0]  rundown_cnt;

  assign runup_cnt    = data_q[46:32];
  assign rundown_sign = data_q[31];
  assign runup_set    = data_q[30:16];
  assign rundown_cnt  = data_q[15:0];

  // Balance is computed modulo 2^18; bit 17 is the sign.
  logic [17:0] balance, balance_neg;
  assign balance     = {2'b00, runup_cnt, 1'b0} - {3'b000, runup_set} - 18'd1;
  assign balance_neg = 18'd0 - balance;

  logic [35:0]        prod_ext, prod_signed, rundown_ext, reading, acc_sum;
  logic signed [35:0] acc_shift;
  logic [4:0]         cnt_inc;

  assign prod_ext    = {6'b0, prod_q};
  assign prod_signed = neg_q ? (36'd0 - prod_ext) : prod_ext;
  assign rundown_ext = {20'b0, rundown_cnt};
  assign reading     = rundown_sign ? (prod_signed - rundown_ext) : (prod_signed + rundown_ext);
  assign acc_sum     = acc_q + reading;
  assign acc_shift   = $signed(acc_sum) >>> AVG_LOG2;
  assign cnt_inc     = cnt_q + 5'd1;

`ifdef VM_RANGE_CHECK_EN
  logic reject;
  logic err_q, err_d;
  assign reject    = ({1'b0, runup_cnt} > ({1'b0, runup_set} + 16'd1)) || (runup_set == 15'h7FFF);
  assign err_range = err_q;
`else
  assign err_range = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{res_data[47], balance_neg[17], acc_shift[35:32]};

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mult_d     = mult_q;
    neg_d      = neg_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    bit_d      = bit_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
`ifdef VM_RANGE_CHECK_EN
    err_d      = 1'b0;
`endif

    if (res_valid && (state_q != S_IDLE)) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (res_valid) begin
          data_d  = res_data[46:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        mult_d  = balance[17] ? balance_neg[16:0] : balance[16:0];
        neg_d   = balance[17];
        mcand_d = WEIGHT;
        prod_d  = '0;
        bit_d   = '0;
        state_d = S_MUL;
`ifdef VM_RANGE_CHECK_EN
        if (reject) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      S_MUL: begin
        // LSB-first shift-add: multiplier shifts right, multiplicand shifts left.
        if (mult_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mult_d  = mult_q >> 1;
        mcand_d = mcand_q << 1;
        if (bit_q == MUL_LAST) begin
          state_d = S_ACC;
        end else begin
          bit_d = bit_q + 5'd1;
        end
      end
      S_ACC: begin
        if (cnt_inc == AVG_N) begin
          out_data_d = acc_shift[31:0];
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = S_OUT;
        end else begin
          acc_d   = acc_sum;
          cnt_d   = cnt_inc;
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear overrides everything, including a sample arriving in the same cycle.
    if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
`ifdef VM_RANGE_CHECK_EN
      err_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      mult_q     <= '0;
      neg_q      <= 1'b0;
      mcand_q    <= '0;
      prod_q     <= '0;
      bit_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
`ifdef VM_RANGE_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mult_q     <= mult_d;
      neg_q      <= neg_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      bit_q      <= bit_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
`ifdef VM_RANGE_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_vm_result_proc.sv
// Randomized self-checking bench: one instance averaging 1 reading, one averaging 4,
// both fed the same samples and checked against an arithmetic reference model.
module tb_vm_result_proc;
  localparam longint WEIGHT = 3200;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        res_valid = 1'b0;
  logic [47:0] res_data = '0;
  logic        clr = 1'b0;
  logic        out_ready = 1'b1;

  logic        out_valid0, ovf0, err0;
  logic [31:0] out_data0;
  logic        out_valid2, ovf2, err2;
  logic [31:0] out_data2;

  always #5 mclk = ~mclk;

  vm_result_proc #(.RUNUP_WEIGHT(3200), .AVG_LOG2(0)) u_dut0 (
    .mclk(mclk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data), .clr(clr),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .ovf(ovf0), .err_range(err0)
  );

  vm_result_proc #(.RUNUP_WEIGHT(3200), .AVG_LOG2(2)) u_dut2 (
    .mclk(mclk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data), .clr(clr),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .ovf(ovf2), .err_range(err2)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  longint grp[$];
  longint last_exp0 = 0;
  longint last_exp2 = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pack(input int cnt, input int sign, input int set, input int rd);
    logic b47;
    b47 = 1'($urandom_range(0, 1));
    return {b47, cnt[14:0], sign[0], set[14:0], rd[15:0]};
  endfunction

  function automatic logic [47:0] rand_sample();
    int set, cnt;
    set = int'($urandom_range(0, 32766));
    cnt = int'($urandom_range(0, set + 1));
    return pack(cnt, int'($urandom_range(0, 1)), set, int'($urandom_range(0, 65535)));
  endfunction

  // Reading = (2*runup_cnt - (runup_set+1)) * weight +/- rundown_cnt
  function automatic longint ref_reading(input logic [47:0] d);
    longint cnt, set, rd, r;
    cnt = longint'(d[46:32]);
    set = longint'(d[30:16]);
    rd  = longint'(d[15:0]);
    r   = (2 * cnt - (set + 1)) * WEIGHT;
    return d[31] ? (r - rd) : (r + rd);
  endfunction

  function automatic longint s32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  task automatic send_raw(input logic [47:0] d);
    @(negedge mclk);
    res_data  = d;
    res_valid = 1'b1;
    @(negedge mclk);
    res_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge mclk);
    clr = 1'b1;
    @(negedge mclk);
    clr = 1'b0;
  endtask

  task automatic watch(input int n, output int v0, output int v2, output int e0, output int e2);
    v0 = 0; v2 = 0; e0 = 0; e2 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge mclk);
      v0 += int'(out_valid0);
      v2 += int'(out_valid2);
      e0 += int'(err0);
      e2 += int'(err2);
    end
  endtask

  task automatic do_sample(input logic [47:0] d, input string tag);
    longint r, sum;
    bit     grp_done;
    int     lat;
    r = ref_reading(d);
    grp.push_back(r);
    grp_done = (grp.size() == 4);
    last_exp0 = longint'(int'(r));
    if (grp_done) begin
      sum = 0;
      foreach (grp[k]) sum += grp[k];
      last_exp2 = longint'(int'(sum >>> 2));
      grp.delete();
    end
    send_raw(d);
    lat = 0;
    while (!out_valid0 && lat < 40) begin
      @(negedge mclk);
      lat++;
    end
    check_val({tag, " latency"}, longint'(lat), 19);
    check_val({tag, " dut0 data"}, s32(out_data0), last_exp0);
    check_val({tag, " dut2 valid"}, longint'(out_valid2), longint'(grp_done));
    if (grp_done) check_val({tag, " dut2 data"}, s32(out_data2), last_exp2);
    $display("txn %s data=%h reading=%0d avg_done=%0d", tag, d, r, grp_done);
    if (out_ready) begin
      @(negedge mclk);
      check_val({tag, " dut0 released"}, longint'(out_valid0), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, v2, e0, e2;

    repeat (3) @(negedge mclk);
    check_val("reset out_valid0", longint'(out_valid0), 0);
    check_val("reset out_valid2", longint'(out_valid2), 0);
    check_val("reset out_data0", s32(out_data0), 0);
    check_val("reset ovf0", longint'(ovf0), 0);
    check_val("reset err0", longint'(err0), 0);
    rst_n = 1'b1;

    do_sample(pack(1000, 0, 1999, 500), "r500");
    do_sample(pack(1000, 0, 1999, 501), "r501");
    do_sample(pack(1000, 0, 1999, 502), "r502");
    do_sample(pack(1000, 1, 1999, 3),   "rm3");
    do_sample(pack(1000, 1, 1999, 1),   "rm1a");
    do_sample(pack(1000, 1, 1999, 1),   "rm1b");
    do_sample(pack(1000, 1, 1999, 1),   "rm1c");
    do_sample(pack(1000, 1, 1999, 2),   "rm2");
    do_sample(pack(1001, 1, 1999, 100), "r6300");
    do_sample(pack(0, 0, 1999, 0),      "rneg6400000");
    do_sample(pack(0, 1, 32766, 65535), "rmin");
`ifdef VM_RANGE_CHECK_EN
    do_sample(pack(32767, 0, 32766, 65535), "rmax");
`else
    do_sample(pack(32767, 0, 0, 65535), "rmax");
`endif
    for (int i = 0; i < 8; i++) do_sample(rand_sample(), "rand");

`ifdef VM_RANGE_CHECK_EN
    do_sample(rand_sample(), "pre_reject");
    send_raw(pack(201, 0, 199, 10));
    watch(25, v0, v2, e0, e2);
    check_val("reject err pulses0", longint'(e0), 1);
    check_val("reject err pulses2", longint'(e2), 1);
    check_val("reject no output", longint'(v0 + v2), 0);
    send_raw(pack(0, 0, 32767, 10));
    watch(25, v0, v2, e0, e2);
    check_val("reject7fff err pulses", longint'(e0 + e2), 2);
    check_val("reject7fff no output", longint'(v0 + v2), 0);
    for (int i = 0; i < 3; i++) do_sample(rand_sample(), "post_reject");
`else
    do_sample(pack(201, 0, 199, 10), "unchecked");
    for (int i = 0; i < 3; i++) do_sample(rand_sample(), "rand");
`endif

    // Stall the consumer with both outputs pending, then overrun.
    for (int i = 0; i < 3; i++) do_sample(rand_sample(), "pre_hold");
    out_ready = 1'b0;
    do_sample(rand_sample(), "hold");
    for (int i = 0; i < 50; i++) begin
      @(negedge mclk);
      check_val("hold data0", s32(out_data0), last_exp0);
      check_val("hold data2", s32(out_data2), last_exp2);
    end
    send_raw(rand_sample());
    repeat (5) @(negedge mclk);
    check_val("overrun ovf0", longint'(ovf0), 1);
    check_val("overrun ovf2", longint'(ovf2), 1);
    check_val("overrun valid0", longint'(out_valid0), 1);
    check_val("overrun data0", s32(out_data0), last_exp0);
    check_val("overrun data2", s32(out_data2), last_exp2);
    pulse_clr();
    check_val("clr ovf0", longint'(ovf0), 0);
    check_val("clr ovf2", longint'(ovf2), 0);
    check_val("clr valid0", longint'(out_valid0), 0);
    check_val("clr valid2", longint'(out_valid2), 0);
    grp.delete();
    out_ready = 1'b1;

    // Handshake and a new sample in the same cycle: sample dropped.
    for (int i = 0; i < 3; i++) do_sample(rand_sample(), "pre_hs");
    out_ready = 1'b0;
    do_sample(rand_sample(), "hs");
    @(negedge mclk);
    out_ready = 1'b1;
    res_data  = rand_sample();
    res_valid = 1'b1;
    @(negedge mclk);
    res_valid = 1'b0;
    check_val("hs valid0", longint'(out_valid0), 0);
    check_val("hs ovf0", longint'(ovf0), 1);
    check_val("hs ovf2", longint'(ovf2), 1);
    watch(25, v0, v2, e0, e2);
    check_val("hs dropped", longint'(v0 + v2), 0);
    pulse_clr();
    check_val("hs clr ovf0", longint'(ovf0), 0);
    grp.delete();

    // clr together with res_valid in IDLE.
    @(negedge mclk);
    res_data  = rand_sample();
    res_valid = 1'b1;
    clr       = 1'b1;
    @(negedge mclk);
    res_valid = 1'b0;
    clr       = 1'b0;
    watch(25, v0, v2, e0, e2);
    check_val("clr_wins no output", longint'(v0 + v2), 0);
    check_val("clr_wins ovf0", longint'(ovf0), 0);

    // Overrun during MUL, then clr aborts the conversion.
    send_raw(rand_sample());
    repeat (3) @(negedge mclk);
    send_raw(rand_sample());
    check_val("mul overrun ovf0", longint'(ovf0), 1);
    check_val("mul overrun ovf2", longint'(ovf2), 1);
    pulse_clr();
    check_val("abort ovf0", longint'(ovf0), 0);
    watch(25, v0, v2, e0, e2);
    check_val("abort no output", longint'(v0 + v2), 0);

    // Reset during MUL with a partially filled average.
    do_sample(rand_sample(), "pre_rst");
    do_sample(rand_sample(), "pre_rst");
    send_raw(rand_sample());
    repeat (8) @(negedge mclk);
    rst_n = 1'b0;
    @(negedge mclk);
    check_val("rst valid0", longint'(out_valid0), 0);
    check_val("rst data0", s32(out_data0), 0);
    check_val("rst data2", s32(out_data2), 0);
    check_val("rst ovf0", longint'(ovf0), 0);
    rst_n = 1'b1;
    grp.delete();
    watch(3, v0, v2, e0, e2);
    check_val("rst no output", longint'(v0 + v2), 0);
    for (int i = 0; i < 4; i++) do_sample(rand_sample(), "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
